onewire_master_seq: RTL
=======================

ONEWIRE_MASTER_SEQ -- requirements
Module: onewire_master_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000, response-wait limit in clk cycles (≥2).
REQ-002 Parameter MAX_RETRY, default 3, retransmissions after first attempt (0..7).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 i_cmd  input  56  command word to send to slave.
REQ-006 i_cmd_valid  input  1  command request; accepted when i_cmd_valid & o_cmd_ready.
REQ-007 o_cmd_ready  output  1  high only in IDLE.
REQ-008 o_tx_data  output  56  word driven to onewire_tx i_tx_data.
REQ-009 o_tx_start  output  1  one-cycle start pulse to onewire_tx.
REQ-010 i_tx_busy  input  1  onewire_tx busy.
REQ-011 i_tx_done  input  1  onewire_tx frame-complete pulse.
REQ-012 i_rx_data  input  56  word decoded by onewire_rx from slave return bus.
REQ-013 i_rx_valid  input  1  one-cycle strobe, i_rx_data valid.
REQ-014 i_rx_error  input  1  one-cycle strobe, received frame bad (CRC/framing).
REQ-015 o_resp  output  56  last good response, held until next good response.
REQ-016 o_resp_valid  output  1  one-cycle pulse when o_resp updated.
REQ-017 o_fail  output  1  one-cycle pulse when all attempts exhausted.
REQ-018 o_retry_cnt  output  3  retries used for current/last command.
REQ-019 o_busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, SEND, WAIT_TX, WAIT_RESP; encoding free.
REQ-021 IDLE: on i_cmd_valid (i_tx_busy low) latch i_cmd into cmd register, clear o_retry_cnt, go SEND next cycle; i_cmd_valid while i_tx_busy high is held off (o_cmd_ready low).
REQ-022 SEND: o_tx_start=1 for exactly one cycle, o_tx_data=cmd register, clear timer, go WAIT_TX.
REQ-023 o_tx_data holds cmd register value continuously from SEND until return to IDLE.
REQ-024 WAIT_TX: on i_tx_done go WAIT_RESP with timer cleared; timer also runs here, expiry treated as failed attempt (REQ-027).
REQ-025 WAIT_RESP: timer increments each cycle; i_rx_valid & !i_rx_error -> o_resp<=i_rx_data, o_resp_valid pulse next cycle, go IDLE.
REQ-026 Attempt fails on i_rx_error in WAIT_RESP or timer reaching TIMEOUT_CYC-1.
REQ-027 Failed attempt: if o_retry_cnt<MAX_RETRY increment o_retry_cnt, go SEND; else pulse o_fail, go IDLE.
REQ-028 Simultaneous i_rx_valid and timer expiry: good response wins; i_rx_valid with i_rx_error counts as error.
REQ-029 i_rx_valid/i_rx_error outside WAIT_RESP ignored; o_resp unchanged.
REQ-030 Timer width ceil(log2(TIMEOUT_CYC))+1 bits; no wrap; cleared on every state entry to SEND.
REQ-031 Command-to-start latency: acceptance in cycle N -> o_tx_start high in cycle N+1.
REQ-032 o_resp_valid and o_fail never asserted in the same cycle.
REQ-033 MAX_RETRY=0: first failure pulses o_fail directly.

Reset
REQ-034 reset low at clk edge: state IDLE, timer 0, cmd register 0.
REQ-035 Reset outputs: o_tx_data=0, o_tx_start=0, o_resp=0, o_resp_valid=0, o_fail=0, o_retry_cnt=0, o_busy=0, o_cmd_ready=1 after reset released.
REQ-036 Reset mid-operation aborts transaction without o_fail or o_resp_valid pulse; pending strobes ignored.

Verification
REQ-037 Reset low 3 cycles, release -> all outputs at REQ-035 values, o_cmd_ready=1.
REQ-038 i_cmd=56'hAA55AA55AA55AA, tx_done after 20 cycles, i_rx_valid with 56'hFFFFFFFFFFFFFF after 50 more -> single o_tx_start, o_resp=56'hFFFFFFFFFFFFFF, o_resp_valid 1 cycle, o_retry_cnt=0.
REQ-039 TIMEOUT_CYC=16, MAX_RETRY=3, no response -> 4 o_tx_start pulses, o_retry_cnt=3, one o_fail pulse, back to IDLE.
REQ-040 i_rx_error on first attempt, good response on second -> o_retry_cnt=1, o_resp_valid, no o_fail.
REQ-041 i_rx_valid on same cycle timer reaches TIMEOUT_CYC-1 -> o_resp_valid, no retry, no o_fail.
REQ-042 reset asserted in WAIT_RESP, i_rx_valid on next cycle -> no o_resp_valid, o_resp=0, IDLE.

Source files
------------

// File: rtl/onewire_master_seq.sv
// -----------------------------------------------------------------------------
// onewire_master_seq
//
// Command/response sequencer that sits between a host and a onewire_tx /
// onewire_rx pair. It accepts one 56-bit command, launches it on the
// transmitter, waits for the slave's reply, and retransmits on a bad or
// missing reply up to MAX_RETRY times before reporting failure.
//
// Parameters
//   TIMEOUT_CYC  response-wait limit in clk cycles (>= 2)
//   MAX_RETRY    retransmissions allowed after the first attempt (0..7)
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-low reset
//   i_cmd         command word to send
//   i_cmd_valid   command request, taken when i_cmd_valid & o_cmd_ready
//   o_cmd_ready   high in IDLE while the transmitter is not busy
//   o_tx_data     command word presented to onewire_tx
//   o_tx_start    one-cycle start pulse to onewire_tx
//   i_tx_busy     onewire_tx busy
//   i_tx_done     onewire_tx frame-complete pulse
//   i_rx_data     word decoded by onewire_rx
//   i_rx_valid    i_rx_data valid strobe
//   i_rx_error    bad received frame strobe
//   o_resp        last good response, held until the next good one
//   o_resp_valid  one-cycle pulse when o_resp is updated
//   o_fail        one-cycle pulse when all attempts are exhausted
//   o_retry_cnt   retries used for the current/last command
//   o_busy        high outside IDLE
// -----------------------------------------------------------------------------
module onewire_master_seq #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [55:0] i_cmd,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  output logic [55:0] o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_busy,
  input  logic        i_tx_done,
  input  logic [55:0] i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_error,
  output logic [55:0] o_resp,
  output logic        o_resp_valid,
  output logic        o_fail,
  output logic [2:0]  o_retry_cnt,
  output logic        o_busy
);

  localparam int              TW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]   TIMER_END = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RESP} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [55:0]     cmd_q;
  logic            good_resp;
  logic            attempt_fail;

  // The command register drives the transmitter directly, so the word is
  // stable from SEND until the sequencer returns to IDLE.
  assign o_tx_data   = cmd_q;
  assign o_busy      = (state != IDLE);
  assign o_cmd_ready = (state == IDLE) && !i_tx_busy;

  // A good response outranks a simultaneous timeout; a strobe carrying
  // i_rx_error is always treated as an error, even with i_rx_valid set.
  assign good_resp = (state == WAIT_RESP) && i_rx_valid && !i_rx_error;

  always_comb begin
    attempt_fail = 1'b0;
    case (state)
      WAIT_TX:   attempt_fail = !i_tx_done && (timer == TIMER_END);
      WAIT_RESP: attempt_fail = !good_resp && (i_rx_error || timer == TIMER_END);
      default:   attempt_fail = 1'b0;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values; later lines may override earlier
  // ones within the same edge (the attempt_fail branch relies on that).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      cmd_q        <= '0;
      o_tx_start   <= 1'b0;
      o_resp       <= '0;
      o_resp_valid <= 1'b0;
      o_fail       <= 1'b0;
      o_retry_cnt  <= '0;
    end else begin
      o_tx_start   <= 1'b0;
      o_resp_valid <= 1'b0;
      o_fail       <= 1'b0;

      case (state)
        IDLE: begin
          if (i_cmd_valid && !i_tx_busy) begin
            cmd_q       <= i_cmd;
            o_retry_cnt <= '0;
            o_tx_start  <= 1'b1;  // registered so the pulse lands in SEND
            state       <= SEND;
          end
        end
        SEND: begin
          timer <= '0;
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            timer <= '0;
            state <= WAIT_RESP;
          end else if (timer != TIMER_END) begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_RESP: begin
          if (good_resp) begin
            o_resp       <= i_rx_data;
            o_resp_valid <= 1'b1;
            state        <= IDLE;
          end else if (timer != TIMER_END) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (attempt_fail) begin
        if (o_retry_cnt < RETRY_MAX) begin
          o_retry_cnt <= o_retry_cnt + 3'd1;
          o_tx_start  <= 1'b1;
          timer       <= '0;
          state       <= SEND;
        end else begin
          o_fail <= 1'b1;
          state  <= IDLE;
        end
      end
    end
  end

endmodule
